// File: rtl/i2s_dac_tx_ctrl.sv
// rtl/i2s_dac_tx_ctrl.sv - I2S DAC transmit controller: BCLK/DACLRC framing, one-entry sample buffer, PISO load/shift control.
module i2s_dac_tx_ctrl #(
  parameter int WD        = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [WD-1:0] s_left_i,
  input  logic [WD-1:0] s_right_i,
  output logic          bclk_o,
  output logic          daclrc_o,
  output logic          piso_en_o,
  output logic          piso_shift_o,
  output logic [WD-1:0] piso_pdata_o,
  output logic          underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam int DCW        = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);
  localparam logic [BCW-1:0] N_SLOT   = BCW'(SLOT_BITS);
  localparam logic [BCW-1:0] N_LOAD_R = BCW'(SLOT_BITS + 1);
  localparam logic [BCW-1:0] N_LOAD_L = BCW'(1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(BCLK_DIV - 1);

  logic [DCW-1:0] div_q, div_d;
  logic           bclk_q, bclk_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           lrc_q, lrc_d;
  logic           full_q, full_d;
  logic [WD-1:0]  buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [WD-1:0]  act_l_q, act_l_d, act_r_q, act_r_d;
  logic           piso_en_q, piso_en_d;
  logic           piso_shift_q, piso_shift_d;
  logic [WD-1:0]  piso_pdata_q, piso_pdata_d;
  logic           underrun_q, underrun_d;
  logic           fe;
  logic [BCW-1:0] n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      bit_q        <= BIT_LAST;
      lrc_q        <= 1'b0;
      full_q       <= 1'b0;
      buf_l_q      <= '0;
      buf_r_q      <= '0;
      act_l_q      <= '0;
      act_r_q      <= '0;
      piso_en_q    <= 1'b0;
      piso_shift_q <= 1'b0;
      piso_pdata_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      bit_q        <= bit_d;
      lrc_q        <= lrc_d;
      full_q       <= full_d;
      buf_l_q      <= buf_l_d;
      buf_r_q      <= buf_r_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
      piso_en_q    <= piso_en_d;
      piso_shift_q <= piso_shift_d;
      piso_pdata_q <= piso_pdata_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    div_d        = div_q;
    bclk_d       = bclk_q;
    bit_d        = bit_q;
    lrc_d        = lrc_q;
    full_d       = full_q;
    buf_l_d      = buf_l_q;
    buf_r_d      = buf_r_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    piso_en_d    = 1'b0;
    piso_shift_d = piso_shift_q;
    piso_pdata_d = '0;
    underrun_d   = 1'b0;
    fe           = 1'b0;
    n            = bit_q;

    // Accept only into an empty buffer; the frame-start consume needs a full one, so they never collide.
    if (s_valid_i && !full_q) begin
      full_d  = 1'b1;
      buf_l_d = s_left_i;
      buf_r_d = s_right_i;
    end

    if (!en_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
      lrc_d  = 1'b0;
      bit_d  = BIT_LAST;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = !bclk_q;
        fe     = bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end

      if (fe) begin
        n     = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        bit_d = n;
        lrc_d = (n >= N_SLOT);
        if (n == '0) begin
          if (full_q) begin
            act_l_d = buf_l_q;
            act_r_d = buf_r_q;
            full_d  = 1'b0;
          end else begin
            act_l_d    = '0;
            act_r_d    = '0;
            underrun_d = 1'b1;
          end
        end else if (n == N_LOAD_L) begin
          piso_en_d    = 1'b1;
          piso_shift_d = 1'b0;
          piso_pdata_d = act_l_q;
        end else if (n == N_LOAD_R) begin
          piso_en_d    = 1'b1;
          piso_shift_d = 1'b0;
          piso_pdata_d = act_r_q;
        end else begin
          piso_en_d    = 1'b1;
          piso_shift_d = 1'b1;
        end
      end
    end
  end

  assign s_ready_o    = !full_q;
  assign bclk_o       = bclk_q;
  assign daclrc_o     = lrc_q;
  assign piso_en_o    = piso_en_q;
  assign piso_shift_o = piso_shift_q;
  assign piso_pdata_o = piso_pdata_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx_ctrl.sv
// tb/tb_i2s_dac_tx_ctrl.sv - scoreboard bench for i2s_dac_tx_ctrl with an attached PISO model.
module tb_i2s_dac_tx_ctrl;
  localparam int WD        = 16;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_DIV  = 2;
  localparam int FB        = 2 * SLOT_BITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          s_valid = 1'b0;
  logic [WD-1:0] s_left = '0;
  logic [WD-1:0] s_right = '0;
  logic          s_ready, bclk, daclrc, piso_en, piso_shift, underrun;
  logic [WD-1:0] piso_pdata;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic dat;
    logic lrc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [WD-1:0] piso_q;
  logic          dacdat;
  int            n_m = FB - 1;
  logic          seen_fe = 1'b0;
  logic          prev_bclk = 1'b0;
  logic          prev_ready = 1'b1;
  logic          fe_now = 1'b0;
  logic          phase_b = 1'b0;
  int            ur_cnt = 0;

  always #5 clk = ~clk;

  i2s_dac_tx_ctrl #(.WD(WD), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_left_i(s_left), .s_right_i(s_right),
    .bclk_o(bclk), .daclrc_o(daclrc),
    .piso_en_o(piso_en), .piso_shift_o(piso_shift),
    .piso_pdata_o(piso_pdata), .underrun_o(underrun)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) piso_q <= '0;
    else if (piso_en) piso_q <= piso_shift ? {piso_q[WD-2:0], 1'b0} : piso_pdata;
  end
  assign dacdat = piso_q[WD-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_frame(input logic [WD-1:0] l, input logic [WD-1:0] r);
    for (int n = 0; n < FB; n++) begin
      exp_t x;
      int p;
      logic [WD-1:0] s;
      p = n % SLOT_BITS;
      s = (n < SLOT_BITS) ? l : r;
      x.lrc = (n >= SLOT_BITS);
      x.dat = (p >= 1 && p <= WD) ? s[WD-p] : 1'b0;
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("drain_in_time", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  task automatic wait_n(input int target, input int budget);
    int c = 0;
    logic hit = 1'b0;
    while (!hit && c < budget) begin
      @(negedge clk);
      #1;
      c++;
      if (fe_now && n_m == target) hit = 1'b1;
    end
    check("reach_n", hit, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bclk"}, bclk, 0);
    check({tag, "_daclrc"}, daclrc, 0);
    check({tag, "_piso_en"}, piso_en, 0);
    check({tag, "_piso_shift"}, piso_shift, 0);
    check({tag, "_piso_pdata"}, piso_pdata, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_s_ready"}, s_ready, 1);
  endtask

  // Monitor: tracks frame position from observed BCLK edges and pops expectations at each rising edge.
  always @(negedge clk) begin
    fe_now = 1'b0;
    if (!rst_n || !en) begin
      n_m       = FB - 1;
      seen_fe   = 1'b0;
      prev_bclk = 1'b0;
    end else begin
      if (prev_bclk && !bclk) begin
        fe_now  = 1'b1;
        n_m     = (n_m + 1) % FB;
        seen_fe = 1'b1;
        check("lrc_at_fe", daclrc, (n_m >= SLOT_BITS));
      end
      if (underrun) begin
        ur_cnt++;
        check("underrun_at_n0", (fe_now && n_m == 0), 1);
      end
      if (phase_b && s_ready && !prev_ready)
        check("ready_after_consume", (fe_now && n_m == 0), 1);
      if (!prev_bclk && bclk && seen_fe && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dacdat", dacdat, e.dat);
        check("daclrc", daclrc, e.lrc);
      end
      prev_bclk = bclk;
    end
    prev_ready = s_ready;
  end

  initial begin
    int first_fe;
    int per;
    int k;
    int c;
    int ur_base;
    logic rdy_prev;

    repeat (3) @(negedge clk);
    check_reset("rst");

    #1;
    rst_n = 1'b1; en = 1'b1;
    s_valid = 1'b1; s_left = 16'hA5C3; s_right = 16'h0F01;
    push_frame(16'hA5C3, 16'h0F01);
    push_frame('0, '0);
    push_frame('0, '0);
    first_fe = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) begin
        check("ready_after_push", s_ready, 0);
        s_valid = 1'b0;
      end
      if (fe_now) begin
        first_fe = i;
        break;
      end
    end
    check("first_fe_clk", first_fe, 4);
    per = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (fe_now) begin
        per = i;
        break;
      end
    end
    check("bclk_period", per, 4);
    wait_drain(1500);
    check("ur_phase_a", ur_cnt, 2);

    en = 1'b0;
    s_valid = 1'b1; s_left = 16'h1000; s_right = 16'h2000;
    @(negedge clk);
    #1;
    check("pair0_taken", s_ready, 0);
    k = 1;
    s_left = 16'h1001; s_right = 16'h2001;
    for (int f = 0; f < 4; f++) push_frame(WD'(16'h1000 + f), WD'(16'h2000 + f));
    ur_base = ur_cnt;
    phase_b = 1'b1;
    en = 1'b1;
    rdy_prev = s_ready;
    c = 0;
    while (k < 4 && c < 2000) begin
      @(negedge clk);
      c++;
      if (rdy_prev) begin
        k++;
        check("single_cycle_ready", s_ready, 0);
      end
      rdy_prev = s_ready;
      #1;
      if (k == 4) s_valid = 1'b0;
      else begin
        s_left  = WD'(16'h1000 + k);
        s_right = WD'(16'h2000 + k);
      end
    end
    s_valid = 1'b0;
    check("pairs_accepted", k, 4);
    wait_drain(1500);
    phase_b = 1'b0;
    check("ur_phase_b", ur_cnt - ur_base, 0);

    ur_base = ur_cnt;
    wait_n(20, 600);
    en = 1'b0;
    s_valid = 1'b1; s_left = 16'h8001; s_right = 16'h7FFE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bclk_parked", bclk, 0);
      check("lrc_parked", daclrc, 0);
      #1;
      s_valid = 1'b0;
    end
    check("buffer_held", s_ready, 0);
    push_frame(16'h8001, 16'h7FFE);
    push_frame('0, '0);
    en = 1'b1;
    wait_drain(1000);
    check("ur_phase_c", ur_cnt - ur_base, 2);

    wait_n(40, 600);
    s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h4321;
    @(negedge clk);
    check("pair_d_taken", s_ready, 0);
    #1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    ur_base = ur_cnt;
    push_frame('0, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(600);
    check("ur_phase_d", ur_cnt - ur_base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
